// File: rtl/mrma_sync_port.sv
// mrma_sync_port: clocked client/resource four-phase controller for the async multi-resource match arbiter
module mrma_sync_port #(
    parameter int N    = 2,
    parameter int M    = 2,
    parameter int IW   = (M > 1) ? $clog2(M) : 1,
    parameter int SYNC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [N-1:0]      rel,
    output logic [N-1:0]      gnt_valid,
    output logic [N*IW-1:0]   gnt_idx,
    input  logic [M-1:0]      res_avail,
    output logic [M-1:0]      res_busy,
    output logic              err,
    output logic [N-1:0]      c,
    input  logic [N-1:0]      ca,
    output logic [M-1:0]      r,
    input  logic [M-1:0]      ra,
    input  logic [M*N-1:0]    cfg
);
    localparam int SW = N + M + M * N;
    typedef enum logic [1:0] {C_IDLE, C_REQ, C_GNT, C_REL} c_state_t;
    typedef enum logic [1:0] {R_IDLE, R_OFF, R_BUSY} r_state_t;
    logic [SYNC-1:0][SW-1:0] sync_q, sync_d;
    logic [N-1:0]   ca_s;
    logic [M-1:0]   ra_s;
    logic [M*N-1:0] cfg_s;
    logic [N-1:0]   bad;
    logic           err_q, err_d;
    assign sync_d = {sync_q[SYNC-2:0], cfg, ra, ca};
    assign {cfg_s, ra_s, ca_s} = sync_q[SYNC-1];
    assign err_d = err_q | (|bad);
    assign err = err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            err_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            err_q  <= err_d;
        end
    end
    for (genvar j = 0; j < N; j++) begin : g_cl
        c_state_t      st_q, st_d;
        logic          c_q, c_d, gv_q, gv_d;
        logic [IW-1:0] idx_q, idx_d, low;
        logic [M-1:0]  col;
        always_comb begin
            col = '0;
            low = '0;
            for (int i = 0; i < M; i++) col[i] = cfg_s[i*N+j];
            for (int i = M - 1; i >= 0; i--) if (col[i]) low = IW'(i);
        end
        // a capture with a zero or multi-hot column still grants the lowest set row
        assign bad[j] = (st_q == C_REQ) && ca_s[j] && !$onehot(col);
        always_comb begin
            st_d  = st_q;
            c_d   = c_q;
            gv_d  = gv_q;
            idx_d = idx_q;
            case (st_q)
                C_IDLE: if (req_valid[j] && !ca_s[j]) begin
                    st_d = C_REQ;
                    c_d  = 1'b1;
                end
                C_REQ: if (ca_s[j]) begin
                    st_d  = C_GNT;
                    gv_d  = 1'b1;
                    idx_d = low;
                end
                C_GNT: if (rel[j]) begin
                    st_d = C_REL;
                    c_d  = 1'b0;
                    gv_d = 1'b0;
                end
                default: st_d = ca_s[j] ? C_REL : C_IDLE;
            endcase
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                st_q  <= C_IDLE;
                c_q   <= 1'b0;
                gv_q  <= 1'b0;
                idx_q <= '0;
            end else begin
                st_q  <= st_d;
                c_q   <= c_d;
                gv_q  <= gv_d;
                idx_q <= idx_d;
            end
        end
        assign c[j] = c_q;
        assign gnt_valid[j] = gv_q;
        assign gnt_idx[j*IW +: IW] = idx_q;
    end
    for (genvar i = 0; i < M; i++) begin : g_rs
        r_state_t st_q, st_d;
        logic     r_q, r_d, busy_q, busy_d;
        always_comb begin
            st_d   = st_q;
            r_d    = r_q;
            busy_d = busy_q;
            case (st_q)
                R_IDLE: if (res_avail[i] && !ra_s[i]) begin
                    st_d = R_OFF;
                    r_d  = 1'b1;
                end
                R_OFF: if (ra_s[i]) begin
                    st_d   = R_BUSY;
                    r_d    = 1'b0;
                    busy_d = 1'b1;
                end
                default: if (!ra_s[i]) begin
                    st_d   = R_IDLE;
                    busy_d = 1'b0;
                end
            endcase
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                st_q   <= R_IDLE;
                r_q    <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                r_q    <= r_d;
                busy_q <= busy_d;
            end
        end
        assign r[i] = r_q;
        assign res_busy[i] = busy_q;
    end
endmodule

// File: doc/mrma_sync_port.md
Name: mrma_sync_port

Overview:
- Synchronous controller that drives both sides of the asynchronous multi-resource match arbiter.
- Client side: raises and releases four-phase client requests (c/ca), then decodes the captured match matrix into a binary resource index per client.
- Resource side: offers free resources (r/ra) and tracks when each one is occupied.
- Sits between the clocked router/NI logic and the self-timed arbiter, and owns all synchronisation of arbiter outputs into the clock domain.

Parameters:
- N, 2, number of clients (columns of the match matrix)
- M, 2, number of resources (rows of the match matrix)
- IW, max(1,clog2(M)), width of one resource index
- SYNC, 2, synchroniser depth for ca, ra and cfg (2 or 3)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active high
- req_valid  input  N  client j wants a resource; level, sampled only in C_IDLE
- rel  input  N  single-cycle pulse: client j releases its resource; honoured only in C_GNT
- gnt_valid  output  N  client j holds a resource
- gnt_idx  output  N*IW  flat vector; slice j is the binary index of the resource matched to client j
- res_avail  input  M  resource i is free to offer; level
- res_busy  output  M  resource i is matched/occupied
- err  output  1  sticky: a cfg column was not one-hot at grant capture
- c  output  N  client requests to arbiter
- ca  input  N  client acks from arbiter (asynchronous)
- r  output  M  resource requests to arbiter
- ra  input  M  resource acks from arbiter (asynchronous)
- cfg  input  M*N  match matrix from arbiter, bit i*N+j = resource i matched to client j (asynchronous)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active high.
- Reset values: c=0, r=0, gnt_valid=0, gnt_idx=0, res_busy=0, err=0. All FSMs go to IDLE and synchroniser flops clear to 0.
- Reset mid-handshake: c and r drop on the first clk edge with rst=1. No wait for ca/ra return. The arbiter's own reset handles cleanup.
- Synchronisation: ca, ra and cfg each pass through SYNC flops, giving ca_s, ra_s, cfg_s. All decisions use only the synchronised copies. Input-to-decision latency is SYNC cycles.
- Client FSM, one per j, with states C_IDLE, C_REQ, C_GNT, C_REL:
  - C_IDLE: if req_valid[j] and ca_s[j]==0, go to C_REQ and set c[j]=1 in the same edge. If ca_s[j] is still 1, stay in C_IDLE (return-to-zero not yet complete).
  - C_REQ: when ca_s[j]==1, capture column j of cfg_s and go to C_GNT.
    - Capture gives gnt_idx[j] = index of the set bit and gnt_valid[j]=1 (registered, visible the cycle after ca_s rises).
    - If the column has zero bits or more than one bit set: set err, load gnt_idx = lowest set bit (0 if none), still grant.
    - cfg is stable whenever ca=1, because the arbiter orders cfg before ca. Capturing from cfg_s in the same cycle as ca_s is therefore safe.
  - C_GNT: hold outputs. On rel[j], set c[j]=0 and gnt_valid[j]=0, go to C_REL. rel in any other state is ignored.
  - C_REL: when ca_s[j]==0, go to C_IDLE. gnt_idx[j] keeps its last value until the next capture.
- Resource FSM, one per i, with states R_IDLE, R_OFF, R_BUSY:
  - R_IDLE: if res_avail[i] and ra_s[i]==0, set r[i]=1 and go to R_OFF.
  - R_OFF: if ra_s[i]==1, go to R_BUSY, set res_busy[i]=1, set r[i]=0 (the arbiter already masks r with ra). If res_avail[i] falls before ra_s rises, keep r[i]=1: a withdrawn offer is not allowed.
  - R_BUSY: when ra_s[i]==0 (the matched client released and the arbiter cleared cfg row i), set res_busy[i]=0 and go to R_IDLE. An immediate re-offer in the same cycle is not allowed; the earliest new r rise is the next cycle.
- Simultaneous events:
  - rel[j] and req_valid[j] in the same cycle in C_GNT: release wins; the new request is considered only after C_IDLE.
  - Multiple clients may capture grants in the same cycle; each captures independently.
- err clears only on rst.

Test Plan:
- Reset: hold rst 3 cycles with req_valid=2'b11 and res_avail=2'b11 -> c=0, r=0, all outputs 0; c and r rise 1 cycle after rst falls.
- Single match, N=M=2: req_valid=01, res_avail=10; model drives cfg[1][0]=1, ca[0]=1, ra[1]=1 -> gnt_valid=01, gnt_idx slice0=1, res_busy=10, all exactly SYNC+1 cycles after ca; err=0.
- Release: pulse rel[0] in C_GNT -> c[0]=0 next edge, gnt_valid[0]=0; model drops ca, ra and cfg -> res_busy[1]=0 SYNC+1 cycles later, then r[1]=1 re-offered the following cycle.
- Dual match: both clients and both resources, cfg=[1][0] and [0][1] -> gnt_idx slices {0:1, 1:0}, gnt_valid=11.
- Malformed cfg: column 0 = 11 on ca[0] rise -> err=1 and sticky, gnt_idx slice0=0, gnt_valid[0]=1.
- Reset in C_GNT with r held -> c and r drop on that edge; no gnt_valid glitch afterwards even while ca stays high.
